// File: rtl/mac16_pipe_acc.sv
// Pipelined multiply-accumulate: optional input and product registers feed an
// accumulator register P with clear, valid tracking, global stall and sticky overflow.
module mac16_pipe_acc #(
    parameter int AW     = 16,
    parameter int BW     = 16,
    parameter int ACCW   = 32,
    parameter int INREG  = 1,
    parameter int MREG   = 1,
    parameter int SIGNED = 0,
    parameter int ACC    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            in_valid,
    input  logic            acc_clear,
    input  logic [AW-1:0]   A,
    input  logic [BW-1:0]   B,
    output logic [ACCW-1:0] P,
    output logic            out_valid,
    output logic            ovf
);

    localparam int PW = AW + BW;

    // Handshake: no backpressure. A sample is taken on every edge with ce=1 and
    // in_valid=1; out_valid marks the edges on which P was loaded by such a sample.
    // ce=0 freezes every register, so in-flight samples simply wait.

    logic [AW-1:0]   a_s;
    logic [BW-1:0]   b_s;
    logic            v_s, c_s;
    logic [ACCW-1:0] prod_x;
    logic [ACCW-1:0] m_p;
    logic            m_v, m_c;
    logic [ACCW:0]   sum;
    logic            add_ovf;

    generate
        if (INREG != 0) begin : g_in_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_s <= '0;
                    b_s <= '0;
                    v_s <= 1'b0;
                    c_s <= 1'b0;
                end else if (ce) begin
                    a_s <= A;
                    b_s <= B;
                    v_s <= in_valid;
                    c_s <= acc_clear;
                end
            end
        end else begin : g_in_pass
            always_comb begin
                a_s = A;
                b_s = B;
                v_s = in_valid;
                c_s = acc_clear;
            end
        end
    endgenerate

    // Operands are widened to the full product width before multiplying so the
    // product is never truncated to the wider operand's width.
    generate
        if (SIGNED != 0) begin : g_mul_s
            logic signed [PW-1:0] prod_s;
            always_comb begin
                prod_s = PW'($signed(a_s)) * PW'($signed(b_s));
                prod_x = ACCW'(prod_s);
            end
        end else begin : g_mul_u
            logic [PW-1:0] prod_u;
            always_comb begin
                prod_u = PW'(a_s) * PW'(b_s);
                prod_x = ACCW'(prod_u);
            end
        end
    endgenerate

    generate
        if (MREG != 0) begin : g_m_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_p <= '0;
                    m_v <= 1'b0;
                    m_c <= 1'b0;
                end else if (ce) begin
                    m_p <= prod_x;
                    m_v <= v_s;
                    m_c <= c_s;
                end
            end
        end else begin : g_m_pass
            always_comb begin
                m_p = prod_x;
                m_v = v_s;
                m_c = c_s;
            end
        end
    endgenerate

    always_comb begin
        sum     = {1'b0, P} + {1'b0, m_p};
        add_ovf = 1'b0;
        if (SIGNED != 0)
            add_ovf = (P[ACCW-1] == m_p[ACCW-1]) && (sum[ACCW-1] != P[ACCW-1]);
        else
            add_ovf = sum[ACCW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P         <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= m_v;
            if (m_v) begin
                if (ACC == 0 || m_c) begin
                    P   <= m_p;
                    ovf <= 1'b0;
                end else begin
                    P <= sum[ACCW-1:0];
                    if (add_ovf)
                        ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac16_pipe_acc.sv
// Bench for mac16_pipe_acc: three configurations (default, signed, load-only
// without registers), directed vectors, per-instance expected queues and monitors.
module tb_mac16_pipe_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
    logic [31:0] p0, p1, p2;
    logic        ov0, ov1, ov2;
    logic        of0, of1, of2;
    logic        upd;

    int checks = 0;
    int failures = 0;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] exp_q2[$];

    mac16_pipe_acc u_def (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(iv0), .acc_clear(clr),
        .A(a), .B(b), .P(p0), .out_valid(ov0), .ovf(of0)
    );

    mac16_pipe_acc #(.SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(iv1), .acc_clear(clr),
        .A(a), .B(b), .P(p1), .out_valid(ov1), .ovf(of1)
    );

    mac16_pipe_acc #(.ACC(0), .INREG(0), .MREG(0)) u_ld (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(iv2), .acc_clear(clr),
        .A(a), .B(b), .P(p2), .out_valid(ov2), .ovf(of2)
    );

    always #5 clk = ~clk;

    // upd marks that the most recent edge was an enabled one
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) upd <= 1'b0;
        else        upd <= ce;
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic issue(input int dut, input logic [15:0] ia, input logic [15:0] ib, input logic ic);
        @(negedge clk);
        ce  = 1'b1;
        a   = ia;
        b   = ib;
        clr = ic;
        iv0 = (dut == 0);
        iv1 = (dut == 1);
        iv2 = (dut == 2);
    endtask

    task automatic idle();
        @(negedge clk);
        ce  = 1'b1;
        iv0 = 1'b0;
        iv1 = 1'b0;
        iv2 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && upd && ov0) begin
            if (exp_q0.size() == 0) check("def_unexpected", {of0, p0}, 33'h0_0000_0000 ^ {of0, p0} ^ 33'h1_FFFF_FFFF);
            else check("def_out", {of0, p0}, exp_q0.pop_front());
        end
        if (rst_n && upd && ov1) begin
            if (exp_q1.size() == 0) check("sgn_unexpected", {of1, p1}, {of1, p1} ^ 33'h1_FFFF_FFFF);
            else check("sgn_out", {of1, p1}, exp_q1.pop_front());
        end
        if (rst_n && upd && ov2) begin
            if (exp_q2.size() == 0) check("ld_unexpected", {of2, p2}, {of2, p2} ^ 33'h1_FFFF_FFFF);
            else check("ld_out", {of2, p2}, exp_q2.pop_front());
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_def", {of0, p0}, '0);
        check("rst_def_v", 33'(ov0), '0);
        check("rst_sgn", {of1, p1}, '0);
        check("rst_sgn_v", 33'(ov1), '0);
        check("rst_ld", {of2, p2}, '0);
        check("rst_ld_v", 33'(ov2), '0);
        rst_n = 1'b1;
        idle();

        // accumulate 3*5 then 2*7; out_valid rises on the third enabled edge
        exp_q0.push_back(33'd15);  issue(0, 16'd3, 16'd5, 1'b1);
        exp_q0.push_back(33'd29);  issue(0, 16'd2, 16'd7, 1'b0);
        idle();
        check("lat_lo", 33'(ov0), 33'd0);
        @(negedge clk);
        check("lat_hi", 33'(ov0), 33'd1);
        repeat (3) idle();

        // unsigned wrap sets sticky ovf; a clear drops it
        exp_q0.push_back({1'b0, 32'hFFFE_0001}); issue(0, 16'hFFFF, 16'hFFFF, 1'b1);
        exp_q0.push_back({1'b1, 32'hFFFC_0002}); issue(0, 16'hFFFF, 16'hFFFF, 1'b0);
        exp_q0.push_back({1'b0, 32'h0000_0001}); issue(0, 16'd1, 16'd1, 1'b1);
        repeat (4) idle();

        // signed: -2*3, +(-1*-1), then positive sums until the MSB flips
        exp_q1.push_back({1'b0, 32'hFFFF_FFFA}); issue(1, 16'hFFFE, 16'd3, 1'b1);
        exp_q1.push_back({1'b0, 32'hFFFF_FFFB}); issue(1, 16'hFFFF, 16'hFFFF, 1'b0);
        exp_q1.push_back({1'b0, 32'h3FFF_0001}); issue(1, 16'h7FFF, 16'h7FFF, 1'b1);
        exp_q1.push_back({1'b0, 32'h7FFE_0002}); issue(1, 16'h7FFF, 16'h7FFF, 1'b0);
        exp_q1.push_back({1'b1, 32'hBFFD_0003}); issue(1, 16'h7FFF, 16'h7FFF, 1'b0);
        repeat (4) idle();

        // load-only, single-cycle latency, streaming then a gap
        exp_q2.push_back(33'd1); issue(2, 16'd1, 16'd1, 1'b0);
        exp_q2.push_back(33'd4); issue(2, 16'd2, 16'd2, 1'b0);
        check("ld_v1", 33'(ov2), 33'd1);
        exp_q2.push_back(33'd9); issue(2, 16'd3, 16'd3, 1'b0);
        check("ld_v2", 33'(ov2), 33'd1);
        idle();
        check("ld_v3", 33'(ov2), 33'd1);
        @(negedge clk);
        check("ld_gap_v", 33'(ov2), 33'd0);
        check("ld_gap_p", {of2, p2}, 33'd9);
        exp_q2.push_back({1'b0, 32'hFFFE_0001}); issue(2, 16'hFFFF, 16'hFFFF, 1'b0);
        exp_q2.push_back({1'b0, 32'hFFFE_0001}); issue(2, 16'hFFFF, 16'hFFFF, 1'b0);
        repeat (3) idle();

        // stall for 5 cycles with junk on the inputs; the sum must resume exactly
        exp_q0.push_back(33'd2);   issue(0, 16'd1, 16'd2, 1'b1);
        exp_q0.push_back(33'd14);  issue(0, 16'd3, 16'd4, 1'b0);
        exp_q0.push_back(33'd44);  issue(0, 16'd5, 16'd6, 1'b0);
        exp_q0.push_back(33'd100);
        @(negedge clk);
        ce = 1'b0; a = 16'd9; b = 16'd9; clr = 1'b1; iv0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_p", {of0, p0}, 33'd2);
            check("stall_v", 33'(ov0), 33'd1);
        end
        issue(0, 16'd7, 16'd8, 1'b0);
        repeat (5) idle();

        // asynchronous reset between edges, with ovf set and a sample in flight
        exp_q0.push_back({1'b0, 32'hFFFE_0001}); issue(0, 16'hFFFF, 16'hFFFF, 1'b1);
        exp_q0.push_back({1'b1, 32'hFFFC_0002}); issue(0, 16'hFFFF, 16'hFFFF, 1'b0);
        issue(0, 16'd1, 16'd1, 1'b0);
        idle();
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_p", {of0, p0}, 33'd0);
        check("arst_v", 33'(ov0), 33'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q0.push_back(33'd20); issue(0, 16'd4, 16'd5, 1'b1);
        exp_q0.push_back(33'd62); issue(0, 16'd6, 16'd7, 1'b0);
        repeat (5) idle();

        for (int i = 0; i < 30 && (exp_q0.size() + exp_q1.size() + exp_q2.size()) > 0; i++)
            @(negedge clk);
        check("drain_def", 33'(exp_q0.size()), 33'd0);
        check("drain_sgn", 33'(exp_q1.size()), 33'd0);
        check("drain_ld", 33'(exp_q2.size()), 33'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
